// File: rtl/decode_pkg.sv
// Shared RV32I decode constants: opcode classes, immediate format codes, classifier result.
// Latency: n/a (package only).
// Backpressure: n/a.
package decode_pkg;

    // Opcode classes, named by instr[6:2]
    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    // Anything that is not a recognised 32-bit RV32I opcode
    localparam logic [4:0] TYPE_INVALID = 5'h1F;

    // Immediate format codes; 6 is reserved and never produced
    localparam logic [2:0] FMT_R    = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_NONE = 3'd7;

    // Classifier result carried into the output register
    typedef struct packed {
        logic [4:0] itype;
        logic [2:0] fmt;
    } class_t;

    // 32-bit encodings always have the two low opcode bits set
    function automatic logic is_32bit_encoding(input logic [1:0] quadrant);
        return quadrant == 2'b11;
    endfunction

endpackage

// File: rtl/imm_extender.sv
// Builds the sign/zero-extended 32-bit immediate for a given instruction format.
// Latency: combinational, 0 cycles.
// Backpressure: none; pure function of its inputs.
module imm_extender
    import decode_pkg::*;
(
    input  logic [31:7] instr,
    input  logic [2:0]  fmt,
    output logic [31:0] imm
);

    logic s;

    assign s = instr[31];

    // Select the bit scatter for the format; R and NONE carry no immediate
    always_comb begin
        imm = 32'h0;
        case (fmt)
            FMT_I: imm = {{20{s}}, instr[31:20]};
            FMT_S: imm = {{20{s}}, instr[31:25], instr[11:7]};
            FMT_B: imm = {{19{s}}, s, instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U: imm = {instr[31:12], 12'b0};
            FMT_J: imm = {{11{s}}, s, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'h0;
        endcase
    end

endmodule

// File: rtl/instr_type_extend_imm.sv
// RV32I decode slice: opcode class, immediate format and extended immediate.
// Latency: 1 cycle, all outputs registered.
// Backpressure: none; a new instruction is accepted every cycle.
module instr_type_extend_imm
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    input  logic [31:0]     instr,
    output logic            out_valid,
    output logic [4:0]      instr_type,
    output logic [2:0]      instr_format,
    output logic [XLEN-1:0] imm
);

    class_t          cls;
    logic [XLEN-1:0] imm_nxt;

    // Classify the opcode; unknown opcodes and 16-bit quadrants fall through to invalid
    always_comb begin
        cls = '{itype: TYPE_INVALID, fmt: FMT_NONE};
        if (is_32bit_encoding(instr[1:0])) begin
            case (instr[6:2])
                OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM:
                    cls = '{itype: instr[6:2], fmt: FMT_I};
                OPC_AUIPC, OPC_LUI:
                    cls = '{itype: instr[6:2], fmt: FMT_U};
                OPC_STORE:
                    cls = '{itype: instr[6:2], fmt: FMT_S};
                OPC_OP:
                    cls = '{itype: instr[6:2], fmt: FMT_R};
                OPC_BRANCH:
                    cls = '{itype: instr[6:2], fmt: FMT_B};
                OPC_JAL:
                    cls = '{itype: instr[6:2], fmt: FMT_J};
                default:
                    cls = '{itype: TYPE_INVALID, fmt: FMT_NONE};
            endcase
        end
    end

    imm_extender u_imm_extender (
        .instr (instr[31:7]),
        .fmt   (cls.fmt),
        .imm   (imm_nxt)
    );

    // Output register; data outputs follow the decode even on invalid cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            instr_type   <= TYPE_INVALID;
            instr_format <= FMT_NONE;
            imm          <= '0;
        end else begin
            out_valid    <= instr_valid;
            instr_type   <= cls.itype;
            instr_format <= cls.fmt;
            imm          <= imm_nxt;
        end
    end

endmodule

// File: tb/tb_instr_type_extend_imm.sv
// Self-checking bench for instr_type_extend_imm: reference decoder plus random and directed stimulus.
// Latency: checks each result one cycle after its input.
// Backpressure: none exercised; input changes every cycle.
module tb_instr_type_extend_imm;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        out_valid;
    logic [4:0]  instr_type;
    logic [2:0]  instr_format;
    logic [31:0] imm;

    int n_checks = 0;
    int n_fail   = 0;

    // Opcode (instr[6:2]) -> format code; 7 marks an illegal opcode
    int fmt_tab [32];

    // Expected outputs for the next sampling point
    logic        exp_v;
    logic [4:0]  exp_t;
    logic [2:0]  exp_f;
    logic [31:0] exp_m;

    instr_type_extend_imm #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .out_valid    (out_valid),
        .instr_type   (instr_type),
        .instr_format (instr_format),
        .imm          (imm)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference decode written from the field-placement rules with shifts and masks
    function automatic void ref_decode(input logic [31:0] i, output logic [4:0] t,
                                       output logic [2:0] f, output logic [31:0] m);
        logic [31:0] sm;
        int          opc;
        sm  = i[31] ? 32'hFFFF_FFFF : 32'h0;
        opc = int'((i >> 2) & 32'h1F);
        t   = 5'h1F;
        f   = 3'd7;
        m   = 32'h0;
        if ((i & 32'h3) == 32'h3 && fmt_tab[opc] != 7) begin
            t = 5'(opc);
            f = 3'(fmt_tab[opc]);
        end
        case (f)
            3'd1: m = (sm << 12) | (i >> 20);
            3'd2: m = (sm << 12) | ((i >> 25) << 5) | ((i >> 7) & 32'h1F);
            3'd3: m = (sm << 12) | (((i >> 7) & 32'h1) << 11) | (((i >> 25) & 32'h3F) << 5)
                      | (((i >> 8) & 32'hF) << 1);
            3'd4: m = i & 32'hFFFF_F000;
            3'd5: m = (sm << 20) | (((i >> 12) & 32'hFF) << 12) | (((i >> 20) & 32'h1) << 11)
                      | (((i >> 21) & 32'h3FF) << 1);
            default: m = 32'h0;
        endcase
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(exp_v));
        chk({tag, ".type"},      32'(instr_type), 32'(exp_t));
        chk({tag, ".format"},    32'(instr_format), 32'(exp_f));
        chk({tag, ".imm"},       imm, exp_m);
    endtask

    task automatic expect_reset();
        exp_v = 1'b0;
        exp_t = 5'h1F;
        exp_f = 3'd7;
        exp_m = 32'h0;
    endtask

    // Check the previous cycle's result, then drive the next input
    task automatic step(input string tag, input logic v, input logic [31:0] ins);
        @(negedge clk);
        check_outputs(tag);
        instr_valid = v;
        instr       = ins;
        exp_v       = v;
        ref_decode(ins, exp_t, exp_f, exp_m);
    endtask

    // Pin the reference model itself against hand-decoded encodings
    task automatic pin_model(input string name, input logic [31:0] i, input logic [4:0] t,
                             input logic [2:0] f, input logic [31:0] m);
        logic [4:0]  mt;
        logic [2:0]  mf;
        logic [31:0] mm;
        ref_decode(i, mt, mf, mm);
        chk({name, ".model_type"}, 32'(mt), 32'(t));
        chk({name, ".model_format"}, 32'(mf), 32'(f));
        chk({name, ".model_imm"}, mm, m);
    endtask

    function automatic logic [31:0] rand_instr();
        int          legal [11] = '{0, 3, 4, 5, 8, 12, 13, 24, 25, 27, 28};
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 9) < 8) begin
            r[6:2] = 5'(legal[$urandom_range(0, 10)]);
            r[1:0] = 2'b11;
        end
        return r;
    endfunction

    initial begin
        for (int k = 0; k < 32; k++) fmt_tab[k] = 7;
        fmt_tab[0]  = 1;  fmt_tab[3]  = 1;  fmt_tab[4]  = 1;  fmt_tab[5]  = 4;
        fmt_tab[8]  = 2;  fmt_tab[12] = 0;  fmt_tab[13] = 4;  fmt_tab[24] = 3;
        fmt_tab[25] = 1;  fmt_tab[27] = 5;  fmt_tab[28] = 1;

        pin_model("addi", 32'hFFF00093, 5'b00100, 3'd1, 32'hFFFF_FFFF);
        pin_model("sw",   32'h0020A423, 5'b01000, 3'd2, 32'h0000_0008);
        pin_model("beq",  32'hFE000EE3, 5'b11000, 3'd3, 32'hFFFF_FFFC);
        pin_model("lui",  32'h123452B7, 5'b01101, 3'd4, 32'h1234_5000);
        pin_model("jal",  32'h001000EF, 5'b11011, 3'd5, 32'h0000_0800);
        pin_model("bad7f",32'h0000007F, 5'h1F,    3'd7, 32'h0000_0000);
        pin_model("bad90",32'h00000090, 5'h1F,    3'd7, 32'h0000_0000);
        pin_model("add",  32'h00B50533, 5'b01100, 3'd0, 32'h0000_0000);

        // Reset state, asserted before any clock edge
        #1 rst = 1'b1;
        #2;
        expect_reset();
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        instr_valid = 1'b0;
        instr = 32'h0;
        expect_reset();
        exp_v = 1'b0;
        ref_decode(32'h0, exp_t, exp_f, exp_m);

        // Directed vectors back to back
        step("pre",   1'b1, 32'hFFF00093);
        step("addi",  1'b1, 32'h0020A423);
        step("sw",    1'b1, 32'hFE000EE3);
        step("beq",   1'b1, 32'h123452B7);
        step("lui",   1'b1, 32'h001000EF);
        step("jal",   1'b0, 32'h0000007F);
        step("bad7f", 1'b1, 32'h00000090);
        step("bad90", 1'b1, 32'h00B50533);
        step("add",   1'b1, 32'h00000013);

        // Random traffic, valid toggling freely
        for (int n = 0; n < 600; n++) begin
            step("rand", 1'($urandom_range(0, 1)), rand_instr());
        end

        // Reset in the middle of a valid stream clears outputs without a clock edge
        step("prerst", 1'b1, 32'hFE000EE3);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        expect_reset();
        check_outputs("midrst_async");
        @(posedge clk);
        #1;
        check_outputs("midrst_held");
        @(negedge clk);
        rst = 1'b0;
        instr_valid = 1'b1;
        instr = 32'h123452B7;
        exp_v = 1'b1;
        ref_decode(32'h123452B7, exp_t, exp_f, exp_m);

        // First post-reset edge decodes normally, then more back-to-back traffic
        step("postrst", 1'b1, 32'h001000EF);
        for (int n = 0; n < 40; n++) begin
            step("rand2", 1'b1, rand_instr());
        end
        step("last", 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
